// File: rtl/ga_mut_pkg.sv
// Shared types and constants for the multi-gene mutation stage:
// mutation modes, FSM state encoding and the LFSR polynomial/seed.
package ga_mut_pkg;

    typedef enum logic [1:0] {
        MODE_BITFLIP = 2'd0,
        MODE_REPLACE = 2'd1,
        MODE_SWAP    = 2'd2,
        MODE_PASS    = 2'd3
    } mut_mode_e;

    // FSM state encoding, kept as plain constants so older blocks can share it
    typedef logic [1:0] mut_state_t;
    localparam mut_state_t ST_IDLE   = 2'd0;
    localparam mut_state_t ST_DRAW   = 2'd1;
    localparam mut_state_t ST_MUTATE = 2'd2;
    localparam mut_state_t ST_PUSH   = 2'd3;

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
    localparam logic [15:0] LFSR_POLY16  = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    // Galois tap mask for a given LFSR width; unlisted widths fall back to the 16-bit taps
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            16:      taps = {16'h0000, LFSR_POLY16};
            24:      taps = 32'h00E1_0000;
            32:      taps = 32'h8020_0003;
            default: taps = {16'h0000, LFSR_POLY16};
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/ga_mutation_multi_if.sv
// Child-in / queue-out handshake bundle of the mutation stage.
// master = producer/consumer side (crossover and downstream queue), slave = mutation block.
interface ga_mutation_multi_if #(
    parameter int DATA_W = 8,
    parameter int M_MAX  = 8
);
    localparam int CHROM_W = DATA_W * M_MAX;

    logic               child_valid;
    logic [CHROM_W-1:0] child;
    logic               child_ack;
    logic               queue_full;
    logic               queue_push;
    logic [CHROM_W-1:0] queue_chromosome;

    modport master (
        output child_valid, child, queue_full,
        input  child_ack, queue_push, queue_chromosome
    );

    modport slave (
        input  child_valid, child, queue_full,
        output child_ack, queue_push, queue_chromosome
    );

endinterface

// File: rtl/ga_lfsr.sv
// Galois LFSR random source. Hard reset loads the default seed, soft reset loads
// the supplied seed (or the default when the seed is zero, to avoid the lock-up state).
module ga_lfsr import ga_mut_pkg::*; #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sw_rst,
    input  logic [W-1:0] seed,
    input  logic         advance,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] POLY        = W'(lfsr_taps(W));
    localparam logic [W-1:0] DEFAULT_VAL = W'(LFSR_DEFAULT);

    // Reseed on either reset, otherwise shift once per advance request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= DEFAULT_VAL;
        end else if (sw_rst) begin
            value <= (seed == '0) ? DEFAULT_VAL : seed;
        end else if (advance) begin
            value <= value[0] ? ((value >> 1) ^ POLY) : (value >> 1);
        end
    end

endmodule

// File: rtl/ga_mutation_multi.sv
// Multi-gene mutation stage of the GA pipeline. Accepts one child, decides once
// whether to mutate it, applies K single-gene mutations (one per cycle) and
// pushes the result into the downstream queue, counting mutated pushes.
module ga_mutation_multi import ga_mut_pkg::*; #(
    parameter  int DATA_W    = 8,
    parameter  int M_MAX     = 8,
    parameter  int MAX_GENES = 4,
    parameter  int LFSR_W    = 16,
    localparam int IDX_W     = $clog2(M_MAX),
    localparam int NG_W      = $clog2(MAX_GENES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw_rst,
    input  logic [IDX_W:0]    cnfg_m,
    input  logic [1:0]        cnfg_mode,
    input  logic [6:0]        cnfg_rate,
    input  logic [NG_W-1:0]   cnfg_num_genes,
    input  logic [LFSR_W-1:0] cnfg_seed,
    ga_mutation_multi_if.slave bus,
    output logic [15:0]       mut_cnt
);

    localparam int CHROM_W = M_MAX * DATA_W;
    localparam int BIT_W   = $clog2(DATA_W);

    mut_state_t         state;
    logic [CHROM_W-1:0] chrom_buf;
    logic [CHROM_W-1:0] mut_buf;
    logic [IDX_W:0]     sh_m;
    mut_mode_e          sh_mode;
    logic [6:0]         sh_rate;
    logic [NG_W-1:0]    sh_left;
    logic [NG_W-1:0]    k_init;
    logic               do_mut;
    logic               draw_hit;

    logic [LFSR_W-1:0]  lfsr;
    logic               lfsr_adv;
    logic               lfsr_unused;

    logic [2*IDX_W:0]   prod1;
    logic [2*IDX_W:0]   prod2;
    logic [IDX_W:0]     idx1_full;
    logic [IDX_W:0]     idx2_full;
    logic [IDX_W-1:0]   idx1;
    logic [IDX_W-1:0]   idx2;
    logic               idx1_ok;
    logic               idx2_ok;
    logic               swap_ok;
    logic [BIT_W-1:0]   flip_sel;
    logic [DATA_W-1:0]  flip_mask;
    logic [DATA_W-1:0]  rnd_gene;
    logic [DATA_W-1:0]  gene_a;
    logic [DATA_W-1:0]  gene_b;

    // The random source only moves while a decision or a gene mutation consumes it
    assign lfsr_adv    = (state == ST_DRAW) || (state == ST_MUTATE);
    assign lfsr_unused = ^lfsr;

    ga_lfsr #(.W(LFSR_W)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .sw_rst  (sw_rst),
        .seed    (cnfg_seed),
        .advance (lfsr_adv),
        .value   (lfsr)
    );

    // Number of mutation cycles for a new child: zero means one, large values clamp to MAX_GENES
    always_comb begin
        if (cnfg_num_genes == '0) begin
            k_init = NG_W'(1);
        end else if (cnfg_num_genes > NG_W'(MAX_GENES)) begin
            k_init = NG_W'(MAX_GENES);
        end else begin
            k_init = cnfg_num_genes;
        end
    end

    // Derive gene indices (scaled into 0..m-1), flip mask and replacement gene from the LFSR
    always_comb begin
        prod1     = {{(IDX_W+1){1'b0}}, lfsr[IDX_W-1:0]} * {{IDX_W{1'b0}}, sh_m};
        prod2     = {{(IDX_W+1){1'b0}}, lfsr[2*IDX_W-1:IDX_W]} * {{IDX_W{1'b0}}, sh_m};
        idx1_full = prod1[2*IDX_W:IDX_W];
        idx2_full = prod2[2*IDX_W:IDX_W];
        idx1      = idx1_full[IDX_W-1:0];
        idx2      = idx2_full[IDX_W-1:0];
        idx1_ok   = (idx1_full < sh_m) && (idx1_full < (IDX_W+1)'(M_MAX));
        idx2_ok   = (idx2_full < sh_m) && (idx2_full < (IDX_W+1)'(M_MAX));
        swap_ok   = idx1_ok && idx2_ok && (idx1 != idx2) && (sh_m > (IDX_W+1)'(1));
        flip_sel  = lfsr[2*IDX_W +: BIT_W];
        flip_mask = {{(DATA_W-1){1'b0}}, 1'b1} << flip_sel;
        rnd_gene  = lfsr[2*IDX_W +: DATA_W];
        draw_hit  = (lfsr[6:0] < sh_rate) && (sh_mode != MODE_PASS);
    end

    // Build the chromosome after one gene mutation; genes outside 0..m-1 are never touched
    always_comb begin
        gene_a  = '0;
        gene_b  = '0;
        for (int i = 0; i < M_MAX; i++) begin
            if (idx1 == IDX_W'(i)) gene_a = chrom_buf[i*DATA_W +: DATA_W];
            if (idx2 == IDX_W'(i)) gene_b = chrom_buf[i*DATA_W +: DATA_W];
        end
        mut_buf = chrom_buf;
        for (int i = 0; i < M_MAX; i++) begin
            if (idx1_ok && (idx1 == IDX_W'(i))) begin
                case (sh_mode)
                    MODE_BITFLIP: mut_buf[i*DATA_W +: DATA_W] = gene_a ^ flip_mask;
                    MODE_REPLACE: mut_buf[i*DATA_W +: DATA_W] = rnd_gene;
                    MODE_SWAP:    if (swap_ok) mut_buf[i*DATA_W +: DATA_W] = gene_b;
                    default:      ;
                endcase
            end
            if (swap_ok && (sh_mode == MODE_SWAP) && (idx2 == IDX_W'(i))) begin
                mut_buf[i*DATA_W +: DATA_W] = gene_a;
            end
        end
    end

    // Control FSM: accept child, draw the mutate decision, mutate K genes, push when the queue has room
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= ST_IDLE;
            bus.child_ack        <= 1'b0;
            bus.queue_push       <= 1'b0;
            bus.queue_chromosome <= '0;
            mut_cnt              <= '0;
            chrom_buf            <= '0;
            sh_m                 <= '0;
            sh_mode              <= MODE_BITFLIP;
            sh_rate              <= '0;
            sh_left              <= '0;
            do_mut               <= 1'b0;
        end else if (sw_rst) begin
            state                <= ST_IDLE;
            bus.child_ack        <= 1'b0;
            bus.queue_push       <= 1'b0;
            bus.queue_chromosome <= '0;
            mut_cnt              <= '0;
            chrom_buf            <= '0;
            sh_m                 <= '0;
            sh_mode              <= MODE_BITFLIP;
            sh_rate              <= '0;
            sh_left              <= '0;
            do_mut               <= 1'b0;
        end else begin
            bus.child_ack  <= 1'b0;
            bus.queue_push <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.child_valid) begin
                        bus.child_ack <= 1'b1;
                        chrom_buf     <= bus.child;
                        sh_m          <= cnfg_m;
                        sh_mode       <= mut_mode_e'(cnfg_mode);
                        sh_rate       <= cnfg_rate;
                        sh_left       <= k_init;
                        state         <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    do_mut <= draw_hit;
                    state  <= draw_hit ? ST_MUTATE : ST_PUSH;
                end
                ST_MUTATE: begin
                    chrom_buf <= mut_buf;
                    sh_left   <= sh_left - NG_W'(1);
                    if (sh_left <= NG_W'(1)) begin
                        state <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    if (!bus.queue_full) begin
                        bus.queue_push       <= 1'b1;
                        bus.queue_chromosome <= chrom_buf;
                        if (do_mut && (mut_cnt != 16'hFFFF)) begin
                            mut_cnt <= mut_cnt + 16'd1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
